muli_elastic: RTL and testbench

- Parametrised, fully elastic integer multiplier for dataflow circuits: joins two operand channels and computes lhs*rhs truncated to DATA_TYPE bits through a LATENCY-cycle pipeline.
- Unlike clock-enable-stalled operators, the pipeline never stalls. A credit counter admits a transaction only if the output FIFO is guaranteed to have room, so a stalled consumer never freezes in-flight results.
- Sits between elastic buffers as a drop-in arithmetic unit. Its ports match the standard two-input/one-output valid/ready operator interface.

---
 rtl/muli_elastic.sv | 143 ++++++++++++++
 tb/tb_muli_elastic.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muli_elastic.sv
// Purpose : elastic two-operand multiplier that returns (lhs*rhs) mod 2^DATA_TYPE.
// Latency : LATENCY cycles from the operand handshake to the earliest result_valid.
// Backpr. : a credit counter admits operands only while the output FIFO has room, so the pipeline never stalls.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   lhs/lhs_valid/lhs_ready     left operand channel
//   rhs/rhs_valid/rhs_ready     right operand channel
//   result/result_valid/result_ready  product channel, driven from the FIFO head
module muli_elastic #(
  parameter int DATA_TYPE  = 32,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  input  logic                 result_ready,
  output logic [DATA_TYPE-1:0] result,
  output logic                 result_valid,
  output logic                 lhs_ready,
  output logic                 rhs_ready
);

  // cnt spans 0..FIFO_DEPTH inclusive; the pointers span 0..FIFO_DEPTH-1.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic                 vld;
    logic [DATA_TYPE-1:0] dat;
  } stage_t;

  logic [CW-1:0]        cnt;
  logic                 credit_ok;
  logic                 fire;
  logic                 pop;
  logic [DATA_TYPE-1:0] prod;
  stage_t               wr;

  // ---------------------------------------------------------------------------
  // Join and credit. Only the registered cnt is used, which keeps result_ready
  // out of the combinational path to the operand ready signals.
  // ---------------------------------------------------------------------------
  assign credit_ok = (cnt < CNT_MAX);
  assign lhs_ready = rhs_valid & credit_ok;
  assign rhs_ready = lhs_valid & credit_ok;
  assign fire      = lhs_valid & rhs_valid & credit_ok;

  // Counts items in the pipeline plus items held in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath. The low DATA_TYPE bits of the product are the same for signed
  // and unsigned operands, so a single unsigned multiply serves both.
  // ---------------------------------------------------------------------------
  assign prod = lhs * rhs;

  generate
    if (LATENCY == 1) begin : g_lat1
      // The product goes straight into the FIFO on the fire edge.
      assign wr = {fire, prod};
    end else begin : g_pipe
      // Free-running shift register. Bubbles travel through it as vld=0.
      stage_t pipe [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            pipe[i].vld <= 1'b0;
          end
        end else begin
          pipe[0] <= {fire, prod};
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign wr = pipe[LATENCY-2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output FIFO: first-word-fall-through circular buffer of any depth. Credit
  // admission guarantees that a write never finds the buffer full.
  // ---------------------------------------------------------------------------
  logic [DATA_TYPE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign result_valid = (occ != '0);
  assign result       = mem[rd_ptr];
  assign pop          = result_valid & result_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr.vld) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr.vld, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occ gates every read.
  always_ff @(posedge clk) begin
    if (wr.vld) begin
      mem[wr_ptr] <= wr.dat;
    end
  end

endmodule

// File: tb/tb_muli_elastic.sv
// Purpose : directed checks of muli_elastic (default instance plus an 8-bit LATENCY=1 instance).
// Latency : n/a.
// Backpr. : exercises consumer stalls through result_ready.
module tb_muli_elastic;

  localparam int W   = 32;
  localparam int LAT = 4;
  localparam int DEP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] lhs, rhs, result;
  logic         lhs_valid, rhs_valid, result_ready;
  logic         result_valid, lhs_ready, rhs_ready;

  logic [7:0]   lhs8, rhs8, result8;
  logic         lhs8_valid, rhs8_valid, result8_ready;
  logic         result8_valid, lhs8_ready, rhs8_ready;

  muli_elastic #(.DATA_TYPE(W), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .lhs_valid    (lhs_valid),
    .rhs          (rhs),
    .rhs_valid    (rhs_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .lhs_ready    (lhs_ready),
    .rhs_ready    (rhs_ready)
  );

  muli_elastic #(.DATA_TYPE(8), .LATENCY(1), .FIFO_DEPTH(2)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs8),
    .lhs_valid    (lhs8_valid),
    .rhs          (rhs8),
    .rhs_valid    (rhs8_valid),
    .result_ready (result8_ready),
    .result       (result8),
    .result_valid (result8_valid),
    .lhs_ready    (lhs8_ready),
    .rhs_ready    (rhs8_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Call in the fire cycle after sampling. Drops the valids and waits for the result.
  task automatic wait_result(input string tag, input logic [W-1:0] exp);
    bit found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      tick();
      if (i == 1) begin
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
      end
      smp();
      if (result_valid) begin
        found = 1'b1;
        chk(tag, result, exp);
        chk({tag, "_lat"}, i, LAT);
      end
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic one_shot(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
    tick();
    lhs = a; rhs = b;
    lhs_valid = 1'b1; rhs_valid = 1'b1;
    result_ready = 1'b1;
    smp();
    chk({tag, "_fire"}, lhs_ready & rhs_ready, 1);
    wait_result(tag, exp);
  endtask

  int fires;
  int j;
  int k;
  logic [W-1:0] e;

  initial begin
    rst = 1'b1;
    lhs = '0; rhs = '0; lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b0;
    lhs8 = '0; rhs8 = '0; lhs8_valid = 1'b0; rhs8_valid = 1'b0; result8_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state; each ready follows the other channel's valid.
    lhs_valid = 1'b1; rhs_valid = 1'b0;
    smp();
    chk("rst_rvld", result_valid, 0);
    chk("rst_cnt", dut.cnt, 0);
    chk("rst_lrdy", lhs_ready, 0);
    chk("rst_rrdy", rhs_ready, 1);

    // Single transaction: 3*5, visible 4 cycles after the fire and only then.
    tick();
    lhs = 3; rhs = 5; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
    smp();
    chk("single_lrdy", lhs_ready, 1);
    chk("single_rrdy", rhs_ready, 1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin lhs_valid = 1'b0; rhs_valid = 1'b0; end
      smp();
      chk("single_vld", result_valid, (c == 4));
      if (c == 4) chk("single_dat", result, 15);
    end
    chk("single_cnt", dut.cnt, 0);

    // Streaming: 20 back-to-back pairs, one result per cycle with no gaps.
    for (int t = 0; t < 26; t++) begin
      tick();
      if (t < 20) begin
        lhs = t; rhs = t + 1; lhs_valid = 1'b1; rhs_valid = 1'b1;
      end else begin
        lhs_valid = 1'b0; rhs_valid = 1'b0;
      end
      smp();
      if (t < 20) chk("stream_fire", lhs_ready & rhs_ready, 1);
      if (t >= 4 && t < 24) begin
        e = (t - 4) * (t - 3);
        chk("stream_vld", result_valid, 1);
        chk("stream_dat", result, e);
      end else begin
        chk("stream_idle", result_valid, 0);
      end
    end

    // Backpressure: exactly DEP fires while the consumer stalls.
    result_ready = 1'b0;
    j = 0; fires = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      lhs = j + 1; rhs = 7; lhs_valid = 1'b1; rhs_valid = 1'b1;
      smp();
      if (lhs_ready && rhs_ready) begin
        fires++;
        j++;
      end
    end
    chk("bp_fires", fires, 5);
    chk("bp_lrdy", lhs_ready, 0);
    chk("bp_rrdy", rhs_ready, 0);
    chk("bp_cnt", dut.cnt, 5);
    chk("bp_head", result, 7);
    // One pop; the freed credit is not visible until the next cycle.
    tick();
    lhs = j + 1; result_ready = 1'b1;
    smp();
    chk("bp_pop_rdy", lhs_ready, 0);
    chk("bp_pop_dat", result, 7);
    tick();
    result_ready = 1'b0;
    smp();
    chk("bp_refire", lhs_ready & rhs_ready, 1);
    chk("bp_head2", result, 14);
    tick();
    smp();
    chk("bp_full_again", lhs_ready, 0);
    // Drain: 14,21,28,35,42 in order.
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b1;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      smp();
      if (result_valid) begin
        chk("bp_drain", result, (k + 2) * 7);
        k++;
      end
      tick();
    end
    chk("bp_count", k, 5);
    chk("bp_cnt0", dut.cnt, 0);

    // Truncation.
    one_shot("wrap32", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    one_shot("neg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    one_shot("shift", 32'h1234_5678, 32'h10, 32'h2345_6780);

    // 8-bit, LATENCY=1: written on the fire edge, visible the next cycle.
    tick();
    lhs8 = 8'h10; rhs8 = 8'h10; lhs8_valid = 1'b1; rhs8_valid = 1'b1;
    smp();
    chk("w8_fire", lhs8_ready & rhs8_ready, 1);
    chk("w8_empty", result8_valid, 0);
    tick();
    lhs8 = 8'h0F; rhs8 = 8'h11;
    smp();
    chk("w8_fire2", lhs8_ready & rhs8_ready, 1);
    chk("w8_vld0", result8_valid, 1);
    chk("w8_dat0", result8, 8'h00);
    tick();
    lhs8_valid = 1'b0; rhs8_valid = 1'b0;
    smp();
    chk("w8_vld1", result8_valid, 1);
    chk("w8_dat1", result8, 8'hFF);
    tick();
    smp();
    chk("w8_idle", result8_valid, 0);

    // Join: lhs alone is never consumed.
    tick();
    lhs = 9; rhs = 11; lhs_valid = 1'b1; rhs_valid = 1'b0; result_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      smp();
      chk("join_lrdy", lhs_ready, 0);
      chk("join_rrdy", rhs_ready, 1);
      chk("join_cnt", dut.cnt, 0);
      tick();
    end
    rhs_valid = 1'b1;
    smp();
    chk("join_fire", lhs_ready & rhs_ready, 1);
    wait_result("join", 99);

    // Reset mid-flight drops everything.
    for (int t = 0; t < 3; t++) begin
      tick();
      lhs = t + 2; rhs = 3; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
      smp();
      chk("rstmf_fire", lhs_ready & rhs_ready, 1);
    end
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0; rst = 1'b1;
    smp();
    tick();
    rst = 1'b0;
    smp();
    chk("rstmf_vld", result_valid, 0);
    chk("rstmf_cnt", dut.cnt, 0);
    for (int t = 0; t < 11; t++) begin
      tick();
      smp();
      chk("rstmf_stale", result_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
